nn_infer_sched: RTL and testbench
=================================

// Module: nn_infer_sched
// PURPOSE
//  Time-multiplexed inference scheduler for the 4-8-1 MLP: one shared MAC replaces the parallel neurons.
//  Walks an external weight memory (hidden weights, then output weights) and latches the 4 inputs on start.
//  Stores 8 hidden sums in local registers and accumulates the output neuron.
//  Presents result, busy/done and state to the top level.
// PARAMETERS
//  N_IN   4   inputs per hidden neuron
//  N_HID  8   hidden neurons (= output-neuron fan-in)
//  X_W    4   input width, unsigned
//  W_W    8   weight width, unsigned
//  (derived localparams) H_W=X_W+W_W+2=14 hidden width; R_W=H_W+W_W+3=25 result width; A_W=6 weight-addr width
// PORTS
//  clk_i     in   1        clock, rising edge
//  rst_i     in   1        asynchronous reset, active-high
//  en_i      in   1        advance enable; low = full stall
//  start_i   in   1        start request, sampled in IDLE only
//  x_i       in   N_IN*X_W packed inputs, x0 in LSBs
//  w_addr_o  out  A_W      weight memory address (combinational-read memory)
//  w_data_i  in   W_W      weight at w_addr_o, valid in the same cycle
//  busy_o    out  1        high in all states except IDLE
//  done_o    out  1        one-cycle pulse in DONE state
//  result_o  out  R_W      output-neuron sum, held until next DONE
//  state_o   out  3        encoded state (IDLE=0 HID=1 HST=2 OUT=3 DONE=4)
// BEHAVIOUR
//  Reset: state IDLE; acc, hidden regs, x latch, result_o, w_addr_o = 0; busy_o = done_o = 0.
//  IDLE: start_i & en_i -> latch x_i, clear acc, set h=0, i=0, go to HID.
//  HID: w_addr_o = h*N_IN+i; acc += x[i]*w_data_i.
//   i==N_IN-1 -> HST; otherwise i++.
//  HST: hid[h] <= acc (exact, no truncation); clear acc; i=0.
//   h==N_HID-1 -> OUT with h=0; otherwise h++ and return to HID.
//  OUT: w_addr_o = N_IN*N_HID+h (32..39); acc += hid[h]*w_data_i.
//   h==N_HID-1 -> DONE.
//  DONE: result_o <= acc; done_o = 1 for one cycle; next state IDLE.
//  Timing: start sampled at edge 0 -> DONE for the cycle after edge 48.
//   done_o and the new result_o are visible after edge 49 (40 hidden + 8 output + 1 done cycles).
//  en_i low: state, counters, acc, w_addr_o and done_o all hold; a pending done_o pulse stays high until en_i returns.
//  Widths: all arithmetic unsigned. The derived widths are exact for all-max operands, so overflow is impossible.
//  start_i outside IDLE (including the DONE cycle) is ignored; back-to-back start is accepted on the IDLE cycle after DONE.
//  x_i changes after the start edge have no effect on the current run.
//  rst_i mid-run aborts immediately to reset values; no done_o is produced.
//  w_addr_o in IDLE and DONE = 0.
// CONFIGURATION
//  NN_SCHED_LOSS_EN defined: adds ports target_i (in, R_W) and loss_o (out, R_W).
//   target_i is latched with x_i at start.
//   loss_o <= |acc - target| is registered in DONE alongside result_o; reset value 0.
//  Undefined: no target_i or loss_o ports and no subtractor; all other behaviour identical.
// STRUCTURE
//  nn_pkg: state enum/encodings, N_IN/N_HID/X_W/W_W defaults, derived H_W/R_W/A_W, OUT_W_BASE=32.
//  Sub-module nn_mac: multiplier plus R_W accumulator with clr/acc/en controls; the scheduler FSM drives it.
//  Hidden register file (8 x H_W) is local to nn_infer_sched.
// TESTING
//  Weights all 1, x=1,1,1,1, start 1 cycle -> hid[*]=4, result_o=32.
//   done_o pulses exactly after edge 49; busy_o is high edges 1..49.
//  x=15 each, weights all 255 -> hid[*]=15300, result_o=31212000 (no wrap).
//  Ramp weights w[a]=a, x=1,2,3,4 -> result_o matches a reference model.
//   w_addr_o sequence is 0..3, 4..7, ..., 28..31, then 32..39.
//  en_i low for 5 cycles mid-HID and again during DONE -> same result; done_o is stretched and completes 5 cycles later per stall.
//  start_i held high through a whole run -> second run begins the cycle after DONE.
//   Inject rst_i at cycle 20 -> all outputs 0, state_o=0, no done_o.
//  NN_SCHED_LOSS_EN, target=40 with the all-1 case -> loss_o=8.
//   Same case with target=20 -> loss_o=12.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared constants, state encoding and helpers for the 4-8-1 MLP inference scheduler.
package nn_pkg;

  localparam int N_IN       = 4;
  localparam int N_HID      = 8;
  localparam int X_W        = 4;
  localparam int W_W        = 8;
  localparam int H_W        = X_W + W_W + 2;
  localparam int R_W        = H_W + W_W + 3;
  localparam int A_W        = 6;
  localparam int OUT_W_BASE = N_IN * N_HID;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HID  = 3'd1,
    ST_HST  = 3'd2,
    ST_OUT  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  function automatic logic [R_W-1:0] abs_diff(input logic [R_W-1:0] a, input logic [R_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/nn_mac.sv
// Shared multiply-accumulate unit: one unsigned product per enabled cycle into a result-width accumulator.
module nn_mac #(
  parameter int OP_W = 14,
  parameter int W_W  = 8,
  parameter int R_W  = 25
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic            clr_i,
  input  logic            acc_i,
  input  logic [OP_W-1:0] a_i,
  input  logic [W_W-1:0]  b_i,
  output logic [R_W-1:0]  acc_o
);

  localparam int P_W = OP_W + W_W;

  logic [P_W-1:0] prod;

  assign prod = P_W'(a_i) * P_W'(b_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_o <= '0;
    end else if (en_i) begin
      if (clr_i) begin
        acc_o <= '0;
      end else if (acc_i) begin
        acc_o <= acc_o + R_W'(prod);
      end
    end
  end

endmodule

// File: rtl/nn_infer_sched.sv
// Time-multiplexed 4-8-1 MLP inference scheduler driving one shared MAC over an external weight memory.
// Optional loss output (|result - target|) is built when NN_SCHED_LOSS_EN is defined.
//
// state | meaning
// IDLE  | waiting for start_i; latches inputs and clears the accumulator
// HID   | hidden MAC step, address h*N_IN+i
// HST   | store exact hidden sum into hid[h], clear accumulator
// OUT   | output MAC step, address OUT_W_BASE+h, operand hid[h]
// DONE  | register result (and loss); done_o pulses on the following cycle
module nn_infer_sched
  import nn_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                start_i,
  input  logic [N_IN*X_W-1:0] x_i,
  output logic [A_W-1:0]      w_addr_o,
  input  logic [W_W-1:0]      w_data_i,
`ifdef NN_SCHED_LOSS_EN
  input  logic [R_W-1:0]      target_i,
  output logic [R_W-1:0]      loss_o,
`endif
  output logic                busy_o,
  output logic                done_o,
  output logic [R_W-1:0]      result_o,
  output logic [2:0]          state_o
);

  localparam int I_W  = $clog2(N_IN);
  localparam int HI_W = $clog2(N_HID);

  state_t          state;
  logic [I_W-1:0]  i_q;
  logic [HI_W-1:0] h_q;
  logic [X_W-1:0]  x_q   [N_IN];
  logic [H_W-1:0]  hid_q [N_HID];

  logic            mac_clr;
  logic            mac_acc;
  logic [H_W-1:0]  mac_a;
  logic [R_W-1:0]  acc;
  logic            last_i;
  logic            last_h;

  assign last_i  = (i_q == I_W'(N_IN - 1));
  assign last_h  = (h_q == HI_W'(N_HID - 1));
  assign state_o = state;

  always_comb begin
    mac_clr = ((state == ST_IDLE) && start_i) || (state == ST_HST);
    mac_acc = (state == ST_HID) || (state == ST_OUT);
    mac_a   = (state == ST_OUT) ? hid_q[h_q] : H_W'(x_q[i_q]);
  end

  nn_mac #(
    .OP_W(H_W),
    .W_W (W_W),
    .R_W (R_W)
  ) u_mac (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (en_i),
    .clr_i (mac_clr),
    .acc_i (mac_acc),
    .a_i   (mac_a),
    .b_i   (w_data_i),
    .acc_o (acc)
  );

  // w_addr_o is registered, so each transition loads the address of the next MAC step.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      i_q      <= '0;
      h_q      <= '0;
      w_addr_o <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      result_o <= '0;
      for (int k = 0; k < N_IN; k++) x_q[k] <= '0;
      for (int k = 0; k < N_HID; k++) hid_q[k] <= '0;
    end else if (en_i) begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            for (int k = 0; k < N_IN; k++) x_q[k] <= x_i[k*X_W +: X_W];
            i_q      <= '0;
            h_q      <= '0;
            w_addr_o <= '0;
            busy_o   <= 1'b1;
            state    <= ST_HID;
          end
        end
        ST_HID: begin
          if (last_i) begin
            state <= ST_HST;
          end else begin
            i_q      <= i_q + 1'b1;
            w_addr_o <= w_addr_o + 1'b1;
          end
        end
        ST_HST: begin
          hid_q[h_q] <= acc[H_W-1:0];
          i_q        <= '0;
          if (last_h) begin
            h_q      <= '0;
            w_addr_o <= A_W'(OUT_W_BASE);
            state    <= ST_OUT;
          end else begin
            h_q      <= h_q + 1'b1;
            w_addr_o <= A_W'((int'(h_q) + 1) * N_IN);
            state    <= ST_HID;
          end
        end
        ST_OUT: begin
          if (last_h) begin
            w_addr_o <= '0;
            state    <= ST_DONE;
          end else begin
            h_q      <= h_q + 1'b1;
            w_addr_o <= w_addr_o + 1'b1;
          end
        end
        ST_DONE: begin
          result_o <= acc;
          done_o   <= 1'b1;
          busy_o   <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef NN_SCHED_LOSS_EN
  logic [R_W-1:0] target_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      target_q <= '0;
      loss_o   <= '0;
    end else if (en_i) begin
      if ((state == ST_IDLE) && start_i) target_q <= target_i;
      if (state == ST_DONE) loss_o <= abs_diff(acc, target_q);
    end
  end
`endif

endmodule

// File: tb/tb_nn_infer_sched.sv
// Self-checking bench for nn_infer_sched: randomized runs against an arithmetic MLP reference model.
module tb_nn_infer_sched;
  import nn_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        en_i = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] x_i = '0;
  logic [5:0]  w_addr_o;
  logic [7:0]  w_data_i;
  logic        busy_o;
  logic        done_o;
  logic [24:0] result_o;
  logic [2:0]  state_o;
`ifdef NN_SCHED_LOSS_EN
  logic [24:0] target_i = '0;
  logic [24:0] loss_o;
`endif

  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  wmem [64];
  int          addr_log[$];
  int          busy_err;

  assign w_data_i = wmem[w_addr_o];

  always #5 clk_i = ~clk_i;

  nn_infer_sched dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (en_i),
    .start_i  (start_i),
    .x_i      (x_i),
    .w_addr_o (w_addr_o),
    .w_data_i (w_data_i),
`ifdef NN_SCHED_LOSS_EN
    .target_i (target_i),
    .loss_o   (loss_o),
`endif
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .state_o  (state_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic longint model(input logic [15:0] xv);
    longint r = 0;
    for (int h = 0; h < 8; h++) begin
      longint s = 0;
      for (int i = 0; i < 4; i++) s += longint'(xv[i*4 +: 4]) * longint'(wmem[h*4+i]);
      r += s * longint'(wmem[32+h]);
    end
    return r;
  endfunction

  task automatic fill_const(input int v);
    for (int a = 0; a < 64; a++) wmem[a] = 8'(v);
  endtask

  // Starts one run and waits (bounded) for done_o; stall_at>=0 drops en_i for 5 cycles from that edge count.
  task automatic run_once(input logic [15:0] xv, input bit hold_start, input int stall_at,
                          input bit stall_done, output int done_edge, output logic [24:0] res);
    int n = 0;
    int dst = 0;
    bit en_prev;
    addr_log.delete();
    busy_err = 0;
    x_i = xv;
    en_i = 1'b1;
    start_i = 1'b1;
    tick();
    if (!hold_start) start_i = 1'b0;
    x_i = 16'($urandom);
`ifdef NN_SCHED_LOSS_EN
    target_i = 25'($urandom);
`endif
    if (state_o == 3'd1 || state_o == 3'd3) addr_log.push_back(int'(w_addr_o));
    while (!done_o && n < 400) begin
      if (!busy_o) busy_err++;
      if (stall_at >= 0 && n >= stall_at && n < stall_at + 5) en_i = 1'b0;
      else if (stall_done && state_o == 3'd4 && dst < 5) begin
        en_i = 1'b0;
        dst++;
      end else en_i = 1'b1;
      en_prev = en_i;
      tick();
      n++;
      if (en_prev && (state_o == 3'd1 || state_o == 3'd3)) addr_log.push_back(int'(w_addr_o));
    end
    en_i = 1'b1;
    done_edge = n;
    res = result_o;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    n_chk++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy_o); end
    n_chk++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", done_o); end
    n_chk++; if (result_o !== 25'd0) begin n_fail++; $display("FAIL reset_result: got %0d expected 0", result_o); end
    n_chk++; if (w_addr_o !== 6'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", w_addr_o); end
`ifdef NN_SCHED_LOSS_EN
    n_chk++; if (loss_o !== 25'd0) begin n_fail++; $display("FAIL reset_loss: got %0d expected 0", loss_o); end
`endif
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_all_ones();
    int de;
    logic [24:0] r;
    fill_const(1);
    run_once(16'h1111, 1'b0, -1, 1'b0, de, r);
    n_chk++; if (r !== 25'd32) begin n_fail++; $display("FAIL ones_result: got %0d expected 32", r); end
    n_chk++; if (de != 49) begin n_fail++; $display("FAIL ones_done_edge: got %0d expected 49", de); end
    n_chk++; if (busy_err != 0) begin n_fail++; $display("FAIL ones_busy_low_in_run: got %0d expected 0", busy_err); end
    n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL ones_busy_at_done: got %0b expected 0", busy_o); end
    tick();
    n_chk++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL ones_done_width: got %0b expected 0", done_o); end
    n_chk++; if (result_o !== 25'd32) begin n_fail++; $display("FAIL ones_result_hold: got %0d expected 32", result_o); end
  endtask

  task automatic test_max();
    int de;
    logic [24:0] r;
    fill_const(255);
    run_once(16'hFFFF, 1'b0, -1, 1'b0, de, r);
    n_chk++; if (r !== 25'd31212000) begin n_fail++; $display("FAIL max_result: got %0d expected 31212000", r); end
    tick();
  endtask

  task automatic test_ramp();
    int de;
    logic [24:0] r;
    longint e;
    for (int a = 0; a < 64; a++) wmem[a] = 8'(a);
    e = model(16'h4321);
    run_once(16'h4321, 1'b0, -1, 1'b0, de, r);
    n_chk++; if (r !== 25'(e)) begin n_fail++; $display("FAIL ramp_result: got %0d expected %0d", r, e); end
    n_chk++; if (addr_log.size() != 40) begin n_fail++; $display("FAIL ramp_addr_count: got %0d expected 40", addr_log.size()); end
    for (int k = 0; k < 40 && k < addr_log.size(); k++) begin
      n_chk++;
      if (addr_log[k] != k) begin n_fail++; $display("FAIL ramp_addr[%0d]: got %0d expected %0d", k, addr_log[k], k); end
    end
    tick();
  endtask

  task automatic test_random();
    int de;
    logic [24:0] r;
    logic [15:0] xv;
    longint e;
    for (int it = 0; it < 4; it++) begin
      for (int a = 0; a < 64; a++) wmem[a] = 8'($urandom);
      xv = 16'($urandom);
      e = model(xv);
      run_once(xv, 1'b0, -1, 1'b0, de, r);
      n_chk++; if (r !== 25'(e)) begin n_fail++; $display("FAIL rand_result[%0d]: got %0d expected %0d", it, r, e); end
      n_chk++; if (de != 49) begin n_fail++; $display("FAIL rand_done_edge[%0d]: got %0d expected 49", it, de); end
      tick();
    end
  endtask

  task automatic test_stall();
    int de;
    logic [24:0] r;
    logic [15:0] xv;
    longint e;
    for (int a = 0; a < 64; a++) wmem[a] = 8'($urandom);
    xv = 16'($urandom);
    e = model(xv);
    run_once(xv, 1'b0, 10, 1'b1, de, r);
    n_chk++; if (r !== 25'(e)) begin n_fail++; $display("FAIL stall_result: got %0d expected %0d", r, e); end
    n_chk++; if (de != 59) begin n_fail++; $display("FAIL stall_done_edge: got %0d expected 59", de); end
    en_i = 1'b0;
    repeat (3) tick();
    n_chk++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL stall_done_stretch: got %0b expected 1", done_o); end
    en_i = 1'b1;
    tick();
    n_chk++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL stall_done_release: got %0b expected 0", done_o); end
  endtask

  task automatic test_back_to_back();
    int de;
    logic [24:0] r;
    logic [15:0] x1, x2;
    longint e1, e2;
    for (int a = 0; a < 64; a++) wmem[a] = 8'($urandom);
    x1 = 16'($urandom);
    x2 = 16'($urandom);
    e1 = model(x1);
    e2 = model(x2);
    run_once(x1, 1'b1, -1, 1'b0, de, r);
    n_chk++; if (r !== 25'(e1)) begin n_fail++; $display("FAIL b2b_result1: got %0d expected %0d", r, e1); end
    n_chk++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL b2b_idle_gap: got %0d expected 0", state_o); end
    run_once(x2, 1'b1, -1, 1'b0, de, r);
    n_chk++; if (de != 49) begin n_fail++; $display("FAIL b2b_done_edge2: got %0d expected 49", de); end
    n_chk++; if (r !== 25'(e2)) begin n_fail++; $display("FAIL b2b_result2: got %0d expected %0d", r, e2); end
    start_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_rst_mid();
    int seen = 0;
    fill_const(3);
    x_i = 16'h2222;
    en_i = 1'b1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (20) tick();
    rst_i = 1'b1;
    #1;
    n_chk++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL rstmid_state: got %0d expected 0", state_o); end
    n_chk++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %0b expected 0", busy_o); end
    n_chk++; if (result_o !== 25'd0) begin n_fail++; $display("FAIL rstmid_result: got %0d expected 0", result_o); end
    n_chk++; if (w_addr_o !== 6'd0) begin n_fail++; $display("FAIL rstmid_addr: got %0d expected 0", w_addr_o); end
    tick();
    rst_i = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (done_o || state_o != 3'd0) seen++;
    end
    n_chk++; if (seen != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d active cycles expected 0", seen); end
  endtask

`ifdef NN_SCHED_LOSS_EN
  task automatic test_loss();
    int de;
    logic [24:0] r;
    fill_const(1);
    target_i = 25'd40;
    run_once(16'h1111, 1'b0, -1, 1'b0, de, r);
    n_chk++; if (loss_o !== 25'd8) begin n_fail++; $display("FAIL loss_t40: got %0d expected 8", loss_o); end
    tick();
    target_i = 25'd20;
    run_once(16'h1111, 1'b0, -1, 1'b0, de, r);
    n_chk++; if (loss_o !== 25'd12) begin n_fail++; $display("FAIL loss_t20: got %0d expected 12", loss_o); end
    tick();
  endtask
`endif

  initial begin
    #2;
    test_reset();
    test_all_ones();
    test_max();
    test_ramp();
    test_random();
    test_stall();
    test_back_to_back();
`ifdef NN_SCHED_LOSS_EN
    test_loss();
`endif
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
